// File: rtl/sd_pkg.sv
// Shared SD host definitions: response FSM states, frame lengths
// and the CRC7 generator polynomial.
package sd_pkg;

    typedef enum logic [1:0] {
        RspIdle,
        RspWaitStart,
        RspReceive,
        RspDone
    } rsp_state_e;

    localparam int RspShortBits = 48;
    localparam int RspLongBits  = 136;

    localparam logic [6:0] Crc7Poly = 7'h09;

endpackage

// File: rtl/sd_rsp_receiver_if.sv
// Control/result bundle between the SD response receiver and the
// host register block.
interface sd_rsp_receiver_if;

    logic         start_i;
    logic         abort_i;
    logic         long_rsp_i;
    logic         check_crc_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] rsp_o;
    logic [5:0]   index_o;
    logic         timeout_err_o;
    logic         crc_err_o;
    logic         end_bit_err_o;

    modport master (
        output start_i, abort_i, long_rsp_i, check_crc_i,
        input  busy_o, done_o, rsp_o, index_o,
        input  timeout_err_o, crc_err_o, end_bit_err_o
    );

    modport slave (
        input  start_i, abort_i, long_rsp_i, check_crc_i,
        output busy_o, done_o, rsp_o, index_o,
        output timeout_err_o, crc_err_o, end_bit_err_o
    );

endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), MSb first, shared by the CMD-line
// transmitter and receiver.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;
    logic       fb;

    always_comb begin
        fb    = bit_i ^ crc_q[6];
        crc_d = crc_q;
        if (clr_i) begin
            crc_d = '0;
        end else if (en_i) begin
            crc_d = {crc_q[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'h00);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_rsp_receiver.sv
// Bit-serial SD command response receiver: start-bit detection with
// Ncr timeout, MSb-first deserialisation, CRC7 and end-bit checking.
module sd_rsp_receiver
    import sd_pkg::*;
#(
    parameter int TimeoutCycles = 64,
    parameter int MaxRspBits    = 136
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sd_clk_en_i,
    input  logic cmd_i,
    sd_rsp_receiver_if.slave bus
);

    localparam int CntW = $clog2(MaxRspBits + 1);
    localparam int ToW  = $clog2(TimeoutCycles + 1);

    rsp_state_e            state_q, state_d;
    logic [ToW-1:0]        to_cnt_q, to_cnt_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [MaxRspBits-1:0] shift_q, shift_d;
    logic                  long_q, long_d;
    logic                  chk_q, chk_d;
    logic [127:0]          rsp_q, rsp_d;
    logic [5:0]            index_q, index_d;
    logic                  to_err_q, to_err_d;
    logic                  crc_err_q, crc_err_d;
    logic                  eb_err_q, eb_err_d;

    logic                  crc_clr;
    logic                  crc_en;
    logic [6:0]            crc_val;
    logic [CntW-1:0]       idx;
    logic [CntW-1:0]       frame_bits;
    logic [ToW-1:0]        to_inc;
    logic [MaxRspBits-1:0] shift_nx;

    sd_crc7 u_crc7 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (crc_clr),
        .en_i  (crc_en),
        .bit_i (cmd_i),
        .crc_o (crc_val)
    );

    always_comb begin
        state_d    = state_q;
        to_cnt_d   = to_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        long_d     = long_q;
        chk_d      = chk_q;
        rsp_d      = rsp_q;
        index_d    = index_q;
        to_err_d   = to_err_q;
        crc_err_d  = crc_err_q;
        eb_err_d   = eb_err_q;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        idx        = bit_cnt_q + 1'b1;
        to_inc     = to_cnt_q + 1'b1;
        frame_bits = long_q ? CntW'(RspLongBits) : CntW'(RspShortBits);
        shift_nx   = {shift_q[MaxRspBits-2:0], cmd_i};

        if (bus.abort_i) begin
            // Abort keeps the last results visible to software
            state_d   = RspIdle;
            to_cnt_d  = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
            crc_clr   = 1'b1;
        end else begin
            unique case (state_q)
                RspIdle: begin
                    if (bus.start_i) begin
                        state_d   = RspWaitStart;
                        long_d    = bus.long_rsp_i;
                        chk_d     = bus.check_crc_i;
                        to_cnt_d  = '0;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        rsp_d     = '0;
                        index_d   = '0;
                        to_err_d  = 1'b0;
                        crc_err_d = 1'b0;
                        eb_err_d  = 1'b0;
                        crc_clr   = 1'b1;
                    end
                end
                RspWaitStart: begin
                    if (sd_clk_en_i) begin
                        if (!cmd_i) begin
                            state_d   = RspReceive;
                            bit_cnt_d = CntW'(1);
                            shift_d   = shift_nx;
                            crc_en    = ~long_q;
                        end else begin
                            to_cnt_d = to_inc;
                            if (to_inc == ToW'(TimeoutCycles)) begin
                                to_err_d = 1'b1;
                                state_d  = RspDone;
                            end
                        end
                    end
                end
                RspReceive: begin
                    if (sd_clk_en_i) begin
                        shift_d   = shift_nx;
                        bit_cnt_d = idx;
                        // Long frames cover only R[127:8] with the CRC
                        crc_en    = long_q
                                  ? (idx >= CntW'(9) && idx <= CntW'(128))
                                  : (idx <= CntW'(40));
                        if (idx == frame_bits) begin
                            state_d   = RspDone;
                            if (long_q) begin
                                rsp_d   = {8'b0, shift_nx[127:8]};
                                index_d = 6'h3F;
                            end else begin
                                rsp_d   = {96'b0, shift_nx[39:8]};
                                index_d = shift_nx[45:40];
                            end
                            crc_err_d = chk_q & (crc_val != shift_nx[7:1]);
                            eb_err_d  = ~cmd_i;
                        end
                    end
                end
                RspDone: begin
                    state_d = RspIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RspIdle;
            to_cnt_q  <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            long_q    <= 1'b0;
            chk_q     <= 1'b0;
            rsp_q     <= '0;
            index_q   <= '0;
            to_err_q  <= 1'b0;
            crc_err_q <= 1'b0;
            eb_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            long_q    <= long_d;
            chk_q     <= chk_d;
            rsp_q     <= rsp_d;
            index_q   <= index_d;
            to_err_q  <= to_err_d;
            crc_err_q <= crc_err_d;
            eb_err_q  <= eb_err_d;
        end
    end

    assign bus.busy_o        = (state_q != RspIdle);
    assign bus.done_o        = (state_q == RspDone);
    assign bus.rsp_o         = rsp_q;
    assign bus.index_o       = index_q;
    assign bus.timeout_err_o = to_err_q;
    assign bus.crc_err_o     = crc_err_q;
    assign bus.end_bit_err_o = eb_err_q;

endmodule

// File: tb/tb_sd_rsp_receiver.sv
// Scoreboard bench for sd_rsp_receiver: directed and random frames
// against a polynomial-division reference model.
module tb_sd_rsp_receiver;

    typedef struct {
        logic [127:0] rsp;
        logic [5:0]   index;
        logic         to_err;
        logic         crc_err;
        logic         eb_err;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic cmd = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t exq[$];

    sd_rsp_receiver_if bus ();

    sd_rsp_receiver dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .sd_clk_en_i (en),
        .cmd_i       (cmd),
        .bus         (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // CRC7 as remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_ref(input logic [119:0] msg,
                                            input int len);
        logic [126:0] v;
        v = {msg, 7'b0};
        for (int i = len + 6; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic exp_t model(input logic [135:0] r, input bit lng,
                                   input bit chkc);
        exp_t e;
        logic [6:0] calc;
        if (lng) begin
            e.rsp   = {8'b0, r[127:8]};
            e.index = 6'h3F;
            calc    = crc7_ref(r[127:8], 120);
        end else begin
            e.rsp   = {96'b0, r[39:8]};
            e.index = r[45:40];
            calc    = crc7_ref({80'b0, r[47:8]}, 40);
        end
        e.to_err  = 1'b0;
        e.crc_err = chkc && (calc != r[7:1]);
        e.eb_err  = ~r[0];
        e.cyc     = 0;
        return e;
    endfunction

    function automatic logic [135:0] short_frame(input logic [5:0] ix,
                                                 input logic [31:0] arg);
        logic [6:0] c;
        c = crc7_ref({80'b0, 2'b00, ix, arg}, 40);
        return {88'b0, 2'b00, ix, arg, c, 1'b1};
    endfunction

    function automatic logic [135:0] long_frame(input logic [119:0] p);
        return {2'b00, 6'h3F, p, crc7_ref(p, 120), 1'b1};
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done_o) begin
            if (exq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exq.pop_front();
                chk("rsp", bus.rsp_o, e.rsp);
                chk("index", 128'(bus.index_o), 128'(e.index));
                chk("timeout_err", 128'(bus.timeout_err_o), 128'(e.to_err));
                chk("crc_err", 128'(bus.crc_err_o), 128'(e.crc_err));
                chk("end_bit_err", 128'(bus.end_bit_err_o), 128'(e.eb_err));
                chk("done_latency", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            en = 1'b0;
            cmd = 1'b1;
            bus.start_i = 1'b0;
            bus.abort_i = 1'b0;
        end
    endtask

    task automatic arm(input bit lng, input bit chkc);
        @(negedge clk);
        en = 1'b0;
        bus.start_i = 1'b1;
        bus.long_rsp_i = lng;
        bus.check_crc_i = chkc;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.long_rsp_i = 1'($urandom);
        bus.check_crc_i = 1'($urandom);
    endtask

    // Gap cycles carry junk on cmd and stray start pulses while busy
    task automatic strobe(input logic b, input int gmin, input int gmax,
                          output int t);
        int g;
        g = $urandom_range(gmax, gmin);
        repeat (g) begin
            @(negedge clk);
            en = 1'b0;
            cmd = 1'($urandom);
            bus.start_i = ($urandom_range(0, 9) == 0);
            bus.long_rsp_i = 1'($urandom);
        end
        @(negedge clk);
        en = 1'b1;
        cmd = b;
        bus.start_i = 1'b0;
        t = cyc;
    endtask

    task automatic send(input logic [135:0] fr, input bit lng,
                        input bit chkc, input int gmax);
        int   n;
        int   t;
        exp_t e;
        n = lng ? 136 : 48;
        arm(lng, chkc);
        repeat ($urandom_range(0, 4)) strobe(1'b1, 0, gmax, t);
        for (int i = n - 1; i >= 0; i--) strobe(fr[i], 0, gmax, t);
        e = model(fr, lng, chkc);
        e.cyc = t + 1;
        exq.push_back(e);
        idle(2);
    endtask

    task automatic send_timeout(input int gap);
        int   t;
        exp_t e;
        arm(1'b0, 1'b1);
        repeat (64) strobe(1'b1, gap, gap, t);
        e.rsp = '0;
        e.index = '0;
        e.to_err = 1'b1;
        e.crc_err = 1'b0;
        e.eb_err = 1'b0;
        e.cyc = t + 1;
        exq.push_back(e);
        idle(2);
    endtask

    task automatic partial(input logic [135:0] fr, input int nbits);
        int t;
        arm(1'b0, 1'b1);
        for (int i = 47; i > 47 - nbits; i--) strobe(fr[i], 0, 1, t);
        @(negedge clk);
        en = 1'b0;
    endtask

    initial begin
        logic [135:0] f1;
        logic [135:0] f;
        logic [127:0] tmp;
        logic [135:0] flip;
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        bus.long_rsp_i = 1'b0;
        bus.check_crc_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 128'(bus.busy_o), 0);
        chk("reset_done", 128'(bus.done_o), 0);
        chk("reset_rsp", bus.rsp_o, 0);
        chk("reset_flags", 128'({bus.index_o, bus.timeout_err_o,
            bus.crc_err_o, bus.end_bit_err_o}), 0);

        f1 = {88'b0, 48'h48_000001AA_87};
        send(f1, 1'b0, 1'b1, 0);
        send({88'b0, 48'h48_000001AA_85}, 1'b0, 1'b1, 2);
        send({88'b0, 48'h48_000001AA_86}, 1'b0, 1'b1, 1);
        send({88'b0, 48'h3F_00FF8000_FF}, 1'b0, 1'b0, 0);
        send_timeout(0);
        send_timeout(2);

        tmp = {$urandom, $urandom, $urandom, $urandom};
        f = long_frame(tmp[119:0]);
        send(f, 1'b1, 1'b1, 1);
        flip = 136'b1 << 60;
        send(f ^ flip, 1'b1, 1'b1, 0);

        partial(f1, 20);
        chk("busy_before_rst", 128'(bus.busy_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 128'(bus.busy_o), 0);
        chk("rst_rsp", bus.rsp_o, 0);
        send(f1, 1'b0, 1'b1, 0);

        partial(f1, 20);
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.abort_i = 1'b0;
        chk("abort_busy", 128'(bus.busy_o), 0);
        idle(4);
        send(f1, 1'b0, 1'b1, 1);

        @(negedge clk);
        bus.start_i = 1'b1;
        bus.abort_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.abort_i = 1'b0;
        chk("start_abort_busy", 128'(bus.busy_o), 0);

        for (int k = 0; k < 16; k++) begin
            bit lng;
            bit chkc;
            lng = ($urandom_range(0, 3) == 0);
            chkc = ($urandom_range(0, 4) != 0);
            if (lng) begin
                tmp = {$urandom, $urandom, $urandom, $urandom};
                f = long_frame(tmp[119:0]);
            end else begin
                f = short_frame(6'($urandom), $urandom);
            end
            if ($urandom_range(0, 3) == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
            if ($urandom_range(0, 5) == 0) f[0] = 1'b0;
            if ($urandom_range(0, 4) == 0) f[lng ? 70 : 20] = ~f[lng ? 70 : 20];
            send(f, lng, chkc, 2);
        end

        idle(5);
        chk("pending_done", 128'(exq.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
